detransformer: RTL and testbench

- Inverse of the compressor-side delta transformer, on the decompressor path after the residue decoder.
- Takes a 256-bit block of per-word residues and rebuilds the original 256-bit block by running prefix summation across eight 32-bit words.
- Also outputs the prediction used for each word, for debug and comparison.
- Single registered stage: one result per cycle, fully pipelined.

---
 rtl/detransformer_pkg.sv | 23 ++
 rtl/detransformer_prefix.sv | 34 +++
 rtl/detransformer.sv | 52 +++++
 tb/tb_detransformer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/detransformer_pkg.sv
// Shared types and constants for the decompressor detransform stage.
// A block is eight 32-bit words; word 0 is the least-significant word.
package detransformer_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int BLK_W     = WORD_W * NUM_WORDS;

  typedef logic [WORD_W-1:0]     word_t;
  typedef word_t [NUM_WORDS-1:0] blk_t;

  localparam word_t WORD_ZERO = 32'h0000_0000;
  localparam blk_t  BLK_ZERO  = {NUM_WORDS{WORD_ZERO}};

  // Word-wide addition; the carry out of bit 31 is discarded so every word
  // wraps independently and nothing leaks into the neighbouring word.
  function automatic word_t add_wrap(input word_t a, input word_t b);
    word_t sum_s;
    sum_s = a + b;
    return sum_s;
  endfunction

endpackage

// File: rtl/detransformer_prefix.sv
// Combinational prefix-sum chain that undoes the delta transform.
// recon[0] = resid[0]; recon[k] = resid[k] + recon[k-1] (mod 2^32).
// pred[k] is the value added to resid[k], i.e. 0 for word 0 and recon[k-1]
// otherwise, so recon[k] = resid[k] + pred[k] holds for every word.
module detransformer_prefix
  import detransformer_pkg::*;
(
  input  logic [BLK_W-1:0] resid,
  output logic [BLK_W-1:0] recon,
  output logic [BLK_W-1:0] pred
);

  blk_t resid_s;
  blk_t recon_s;
  blk_t pred_s;

  assign resid_s = resid;

  // Ripple the running sum from the base word upward, one adder per word.
  always_comb begin
    recon_s    = BLK_ZERO;
    pred_s     = BLK_ZERO;
    pred_s[0]  = WORD_ZERO;
    recon_s[0] = resid_s[0];
    for (int k = 1; k < NUM_WORDS; k++) begin
      pred_s[k]  = recon_s[k-1];
      recon_s[k] = add_wrap(resid_s[k], pred_s[k]);
    end
  end

  assign recon = recon_s;
  assign pred  = pred_s;

endmodule

// File: rtl/detransformer.sv
// Detransformer: rebuilds a 256-bit block from per-word residues and
// registers the result together with the per-word prediction.
// One block per cycle, one cycle of latency, no backpressure.
module detransformer
  import detransformer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [BLK_W-1:0] data_i,
  output logic             valid_o,
  output logic [BLK_W-1:0] data_o,
  output logic [BLK_W-1:0] pred_o
);

  logic [BLK_W-1:0] recon_s;
  logic [BLK_W-1:0] pred_s;

  logic             valid_r;
  logic [BLK_W-1:0] data_r;
  logic [BLK_W-1:0] pred_r;

  detransformer_prefix u_prefix (
    .resid (data_i),
    .recon (recon_s),
    .pred  (pred_s)
  );

  // Output register: reset clears everything and drops any block arriving on
  // the same edge; idle cycles clear valid but keep the last block visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {BLK_W{1'b0}};
      pred_r  <= {BLK_W{1'b0}};
    end else begin
      valid_r <= valid_i;
      if (valid_i) begin
        data_r <= recon_s;
        pred_r <= pred_s;
      end else begin
        data_r <= data_r;
        pred_r <= pred_r;
      end
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign pred_o  = pred_r;

endmodule

// File: tb/tb_detransformer.sv
// Directed self-checking bench for the detransformer.
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. one rising edge after the block was presented.
module tb_detransformer;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [255:0] data_i;
  logic         valid_o;
  logic [255:0] data_o;
  logic [255:0] pred_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  detransformer dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .pred_o  (pred_o)
  );

  // Hand-computed vectors (word 7 leftmost).
  localparam logic [255:0] R_BASE = {224'h0, 32'h1234_5678};
  localparam logic [255:0] D_BASE = {8{32'h1234_5678}};
  localparam logic [255:0] P_BASE = {{7{32'h1234_5678}}, 32'h0};

  localparam logic [255:0] R_ONES = {8{32'h0000_0001}};
  localparam logic [255:0] D_ONES = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [255:0] P_ONES = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};

  localparam logic [255:0] R_WRAP = {192'h0, 32'h0000_0002, 32'hFFFF_FFFF};
  localparam logic [255:0] D_WRAP = {{7{32'h0000_0001}}, 32'hFFFF_FFFF};
  localparam logic [255:0] P_WRAP = {{6{32'h0000_0001}}, 32'hFFFF_FFFF, 32'h0};

  localparam logic [255:0] R_RAMP = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [255:0] D_RAMP = {32'h24, 32'h1C, 32'h15, 32'hF, 32'hA, 32'h6, 32'h3, 32'h1};
  localparam logic [255:0] P_RAMP = {32'h1C, 32'h15, 32'hF, 32'hA, 32'h6, 32'h3, 32'h1, 32'h0};

  localparam logic [255:0] R_HALF = {8{32'h8000_0000}};
  localparam logic [255:0] D_HALF = {4{32'h0, 32'h8000_0000}};
  localparam logic [255:0] P_HALF = {4{32'h8000_0000, 32'h0}};

  // Present one set of inputs for one rising edge, then wait for the
  // following falling edge so outputs are stable for sampling.
  task automatic step(input logic r, input logic v, input logic [255:0] d);
    rst     = r;
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, {256{1'b1}});
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", c, valid_o);
      end
      n_cmp++;
      if (data_o !== 256'h0) begin
        n_err++;
        $display("FAIL reset_data cyc%0d: got %h want 0", c, data_o);
      end
      n_cmp++;
      if (pred_o !== 256'h0) begin
        n_err++;
        $display("FAIL reset_pred cyc%0d: got %h want 0", c, pred_o);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [255:0] r,
                             input logic [255:0] d_exp, input logic [255:0] p_exp);
    step(1'b0, 1'b1, r);
    n_cmp++;
    if (valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_valid: got %b want 1", name, valid_o);
    end
    n_cmp++;
    if (data_o !== d_exp) begin
      n_err++;
      $display("FAIL %s_data: got %h want %h", name, data_o, d_exp);
    end
    n_cmp++;
    if (pred_o !== p_exp) begin
      n_err++;
      $display("FAIL %s_pred: got %h want %h", name, pred_o, p_exp);
    end
  endtask

  task automatic test_streaming();
    logic [255:0] rv [3];
    logic [255:0] dv [3];
    logic [255:0] pv [3];
    rv[0] = R_RAMP; dv[0] = D_RAMP; pv[0] = P_RAMP;
    rv[1] = R_HALF; dv[1] = D_HALF; pv[1] = P_HALF;
    rv[2] = R_BASE; dv[2] = D_BASE; pv[2] = P_BASE;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, rv[i]);
      n_cmp++;
      if (valid_o !== 1'b1) begin
        n_err++;
        $display("FAIL stream%0d_valid: got %b want 1", i, valid_o);
      end
      n_cmp++;
      if (data_o !== dv[i]) begin
        n_err++;
        $display("FAIL stream%0d_data: got %h want %h", i, data_o, dv[i]);
      end
      n_cmp++;
      if (pred_o !== pv[i]) begin
        n_err++;
        $display("FAIL stream%0d_pred: got %h want %h", i, pred_o, pv[i]);
      end
    end
    // Idle cycles with junk on data_i: valid drops, last block is held.
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, R_ONES);
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL idle%0d_valid: got %b want 0", c, valid_o);
      end
      n_cmp++;
      if (data_o !== D_BASE) begin
        n_err++;
        $display("FAIL idle%0d_data_hold: got %h want %h", c, data_o, D_BASE);
      end
      n_cmp++;
      if (pred_o !== P_BASE) begin
        n_err++;
        $display("FAIL idle%0d_pred_hold: got %h want %h", c, pred_o, P_BASE);
      end
    end
  endtask

  task automatic test_midstream_reset();
    step(1'b0, 1'b1, R_RAMP);
    n_cmp++;
    if (data_o !== D_RAMP) begin
      n_err++;
      $display("FAIL mid_pre_data: got %h want %h", data_o, D_RAMP);
    end
    // Reset on the same edge as a valid block: the block is dropped.
    step(1'b1, 1'b1, R_HALF);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_valid: got %b want 0", valid_o);
    end
    n_cmp++;
    if (data_o !== 256'h0) begin
      n_err++;
      $display("FAIL mid_rst_data: got %h want 0", data_o);
    end
    n_cmp++;
    if (pred_o !== 256'h0) begin
      n_err++;
      $display("FAIL mid_rst_pred: got %h want 0", pred_o);
    end
    test_single("mid_post", R_WRAP, D_WRAP, P_WRAP);
    step(1'b0, 1'b0, 256'h0);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_tail_valid: got %b want 0", valid_o);
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 256'h0;
    test_reset();
    test_single("base", R_BASE, D_BASE, P_BASE);
    test_single("ones", R_ONES, D_ONES, P_ONES);
    test_single("wrap", R_WRAP, D_WRAP, P_WRAP);
    test_single("half", R_HALF, D_HALF, P_HALF);
    test_streaming();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
